// File: rtl/pb_port_pkg.sv
// ----------------------------------------------------------------------------
// pb_port_pkg
// Shared constants and types for the port-bus master: bus widths, read-latency
// limits, FSM state encoding, the latched command payload and a wait helper.
// ----------------------------------------------------------------------------
package pb_port_pkg;

    localparam int unsigned ADDR_W         = 8;
    localparam int unsigned DATA_W         = 8;
    localparam int unsigned RD_LAT_DEFAULT = 1;
    localparam int unsigned RD_LAT_MAX     = 4;
    localparam int unsigned WAIT_CNT_W     = $clog2(RD_LAT_MAX);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4
    } pb_state_e;

    // Command captured at the acceptance edge.
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } pb_cmd_t;

    // True in the final WAIT cycle (the counter starts at 0 on WAIT entry).
    function automatic logic is_last_wait(input logic [WAIT_CNT_W-1:0] cnt,
                                          input int unsigned           lat);
        return cnt == WAIT_CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/pb_port_master_if.sv
// ----------------------------------------------------------------------------
// pb_port_master_if
// Bundles the command/response handshake and the peripheral port bus.
//   master : view of pb_port_master (drives cmd_ready, rsp_*, port_id,
//            out_port, strobes; receives cmd_*, rsp_ready, in_port)
//   slave  : opposite view for the requester/peripheral side
// ----------------------------------------------------------------------------
interface pb_port_master_if;
    import pb_port_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] port_id;
    logic [DATA_W-1:0] out_port;
    logic              write_strobe;
    logic              read_strobe;
    logic [DATA_W-1:0] in_port;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, in_port,
        output cmd_ready, rsp_valid, rsp_rdata, port_id, out_port,
               write_strobe, read_strobe
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, in_port,
        input  cmd_ready, rsp_valid, rsp_rdata, port_id, out_port,
               write_strobe, read_strobe
    );

endinterface

// File: rtl/pb_irq_sync.sv
// ----------------------------------------------------------------------------
// pb_irq_sync  (built only with PB_PORT_MASTER_IRQ_EN)
// Two-flop synchronizer on the interrupt line plus a sticky pending flag set
// by a rising edge and cleared by acknowledge; a new edge wins over ack.
//   clk, reset       : clock, async active-high reset
//   i_interrupt      : asynchronous interrupt request
//   i_irq_ack        : clears the pending flag
//   o_irq_pending    : sticky pending flag
// ----------------------------------------------------------------------------
`ifdef PB_PORT_MASTER_IRQ_EN
module pb_irq_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_interrupt,
    input  logic i_irq_ack,
    output logic o_irq_pending
);

    logic [1:0] r_sync;
    logic       r_prev;
    logic       r_pending;
    logic       w_rise;

    assign w_rise = r_sync[1] & ~r_prev;

    // Synchronizer, edge history and sticky flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync    <= '0;
            r_prev    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_interrupt};
            r_prev    <= r_sync[1];
            r_pending <= w_rise | (r_pending & ~i_irq_ack);
        end
    end

    assign o_irq_pending = r_pending;

endmodule
`endif

// File: rtl/pb_port_master.sv
// ----------------------------------------------------------------------------
// pb_port_master
// Turns valid/ready commands into port-bus cycles: SETUP presents port_id and
// out_port, STROBE pulses write_strobe or read_strobe for one cycle, WAIT
// covers READ_LATENCY cycles before in_port is captured, RESP holds the
// response until rsp_ready.
//   parameter READ_LATENCY : 1..4, cycles from read_strobe to in_port capture
//   clk, reset             : clock, async active-high reset
//   bus (master modport)   : cmd_*, rsp_*, port_id, out_port, strobes, in_port
//   interrupt, irq_ack, irq_pending : present only with PB_PORT_MASTER_IRQ_EN
// ----------------------------------------------------------------------------
module pb_port_master
    import pb_port_pkg::*;
#(
    parameter int unsigned READ_LATENCY = RD_LAT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    pb_port_master_if.master bus
`ifdef PB_PORT_MASTER_IRQ_EN
    ,
    input  logic             interrupt,
    input  logic             irq_ack,
    output logic             irq_pending
`endif
);

    pb_state_e             r_state;
    pb_state_e             w_next_state;
    pb_cmd_t               r_cmd;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;

    logic                  r_cmd_ready;
    logic                  r_rsp_valid;
    logic                  r_wr_strobe;
    logic                  r_rd_strobe;
    logic [DATA_W-1:0]     r_rsp_rdata;
    logic [ADDR_W-1:0]     r_port_id;
    logic [DATA_W-1:0]     r_out_port;

    logic                  w_accept;
    logic                  w_wait_done;
    logic                  w_cmd_ready_d;
    logic                  w_rsp_valid_d;
    logic                  w_wr_strobe_d;
    logic                  w_rd_strobe_d;

    assign w_accept    = (r_state == ST_IDLE) && r_cmd_ready && bus.cmd_valid;
    assign w_wait_done = is_last_wait(r_wait_cnt, READ_LATENCY);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next_state = ST_SETUP;
            ST_SETUP:  w_next_state = ST_STROBE;
            ST_STROBE: w_next_state = r_cmd.write ? ST_RESP : ST_WAIT;
            ST_WAIT:   if (w_wait_done) w_next_state = ST_RESP;
            ST_RESP:   if (bus.rsp_ready) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs line up
    // with the state they belong to.
    always_comb begin
        w_cmd_ready_d = 1'b0;
        w_rsp_valid_d = 1'b0;
        w_wr_strobe_d = 1'b0;
        w_rd_strobe_d = 1'b0;
        case (w_next_state)
            ST_IDLE:   w_cmd_ready_d = 1'b1;
            ST_STROBE: begin
                w_wr_strobe_d = r_cmd.write;
                w_rd_strobe_d = ~r_cmd.write;
            end
            ST_RESP:   w_rsp_valid_d = 1'b1;
            default:   ;
        endcase
    end

    // Registered outputs, command latch, wait counter and read capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_rd_strobe <= 1'b0;
            r_rsp_rdata <= '0;
            r_port_id   <= '0;
            r_out_port  <= '0;
            r_cmd       <= '0;
            r_wait_cnt  <= '0;
        end else begin
            r_cmd_ready <= w_cmd_ready_d;
            r_rsp_valid <= w_rsp_valid_d;
            r_wr_strobe <= w_wr_strobe_d;
            r_rd_strobe <= w_rd_strobe_d;

            // port_id/out_port load with the command and then hold until the
            // next acceptance.
            if (w_accept) begin
                r_cmd.write <= bus.cmd_write;
                r_cmd.addr  <= bus.cmd_addr;
                r_cmd.wdata <= bus.cmd_wdata;
                r_port_id   <= bus.cmd_addr;
                r_out_port  <= bus.cmd_wdata;
            end

            if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt + WAIT_CNT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end

            // Writes report 0x00; reads sample in_port on the last WAIT edge.
            if (r_state == ST_STROBE && r_cmd.write) begin
                r_rsp_rdata <= '0;
            end else if (r_state == ST_WAIT && w_wait_done) begin
                r_rsp_rdata <= bus.in_port;
            end
        end
    end

    assign bus.cmd_ready    = r_cmd_ready;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_rdata    = r_rsp_rdata;
    assign bus.port_id      = r_port_id;
    assign bus.out_port     = r_out_port;
    assign bus.write_strobe = r_wr_strobe;
    assign bus.read_strobe  = r_rd_strobe;

`ifdef PB_PORT_MASTER_IRQ_EN
    pb_irq_sync u_irq_sync (
        .clk           (clk),
        .reset         (reset),
        .i_interrupt   (interrupt),
        .i_irq_ack     (irq_ack),
        .o_irq_pending (irq_pending)
    );
`endif

endmodule

// File: tb/tb_pb_port_master.sv
// ----------------------------------------------------------------------------
// tb_pb_port_master
// Two instances (READ_LATENCY 1 and 4) behind a shared driver; `sel` picks
// the active one. Accepted commands are pushed to a scoreboard and checked
// when strobes and responses appear. A model peripheral returns its data on
// in_port only in the single cycle matching the configured latency.
// ----------------------------------------------------------------------------
module tb_pb_port_master;
    import pb_port_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       sel = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_ready = 1'b1;
    logic       irq_in = 1'b0;
    logic       irq_ack = 1'b0;
    logic       irq_pend1;
    logic       irq_pend4;

    pb_port_master_if if1 ();
    pb_port_master_if if4 ();

    pb_port_master #(.READ_LATENCY(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
`ifdef PB_PORT_MASTER_IRQ_EN
        ,
        .interrupt   (irq_in),
        .irq_ack     (irq_ack),
        .irq_pending (irq_pend1)
`endif
    );

    pb_port_master #(.READ_LATENCY(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4)
`ifdef PB_PORT_MASTER_IRQ_EN
        ,
        .interrupt   (irq_in),
        .irq_ack     (irq_ack),
        .irq_pending (irq_pend4)
`endif
    );

    assign if1.cmd_valid = cmd_valid & ~sel;
    assign if4.cmd_valid = cmd_valid & sel;
    assign if1.cmd_write = cmd_write;
    assign if4.cmd_write = cmd_write;
    assign if1.cmd_addr  = cmd_addr;
    assign if4.cmd_addr  = cmd_addr;
    assign if1.cmd_wdata = cmd_wdata;
    assign if4.cmd_wdata = cmd_wdata;
    assign if1.rsp_ready = rsp_ready;
    assign if4.rsp_ready = rsp_ready;

    logic       m_cmd_ready, m_rsp_valid, m_ws, m_rs;
    logic [7:0] m_rdata, m_pid, m_out;
    assign m_cmd_ready = sel ? if4.cmd_ready    : if1.cmd_ready;
    assign m_rsp_valid = sel ? if4.rsp_valid    : if1.rsp_valid;
    assign m_ws        = sel ? if4.write_strobe : if1.write_strobe;
    assign m_rs        = sel ? if4.read_strobe  : if1.read_strobe;
    assign m_rdata     = sel ? if4.rsp_rdata    : if1.rsp_rdata;
    assign m_pid       = sel ? if4.port_id      : if1.port_id;
    assign m_out       = sel ? if4.out_port     : if1.out_port;

    // Peripheral contents.
    function automatic logic [7:0] periph_val(input logic [7:0] a);
        if (a == 8'h01) return 8'h3C;
        if (a == 8'h40) return 8'h5A;
        return a ^ 8'h96;
    endfunction

    // Registered peripheral: valid data only in the capture cycle, 0xEE otherwise.
    logic [2:0] sr4 = 3'b000;
    always @(posedge clk) begin
        if1.in_port <= if1.read_strobe ? periph_val(if1.port_id) : 8'hEE;
        sr4         <= {sr4[1:0], if4.read_strobe};
        if4.in_port <= sr4[2] ? periph_val(if4.port_id) : 8'hEE;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         t_acc;
    } txn_t;

    txn_t sb[$];
    bit   front_strobed = 1'b0;
    bit   prev_rv = 1'b0;
    logic [7:0] first_rdata = 8'h00;
    int   last_hs = 0;

    // Monitor: samples just after the falling edge.
    always @(negedge clk) begin
        #1;
        if (reset) begin
            sb.delete();
            front_strobed = 1'b0;
            prev_rv = 1'b0;
        end else begin
            if (m_ws || m_rs) begin
                check_val("strobe_excl", 32'(m_ws & m_rs), 32'd0);
                check_val("strobe_stray", 32'(sb.size() == 0 || front_strobed), 32'd0);
                if (sb.size() != 0) begin
                    check_val("strobe_kind", 32'(m_ws), 32'(sb[0].wr));
                    check_val("strobe_time", 32'(cyc), 32'(sb[0].t_acc + 1));
                    check_val("strobe_port_id", 32'(m_pid), 32'(sb[0].addr));
                    if (sb[0].wr) check_val("strobe_out_port", 32'(m_out), 32'(sb[0].wdata));
                    front_strobed = 1'b1;
                end
            end
            if (m_rsp_valid) begin
                check_val("cmd_ready_in_resp", 32'(m_cmd_ready), 32'd0);
                check_val("rsp_stray", 32'(sb.size() == 0), 32'd0);
                if (sb.size() != 0) begin
                    if (!prev_rv) begin
                        check_val("rsp_time", 32'(cyc),
                                  32'(sb[0].t_acc + 2 + (sb[0].wr ? 0 : (sel ? 4 : 1))));
                        check_val("rsp_after_strobe", 32'(front_strobed), 32'd1);
                        first_rdata = m_rdata;
                    end else begin
                        check_val("rsp_stable", 32'(m_rdata), 32'(first_rdata));
                    end
                    if (rsp_ready) begin
                        check_val("rsp_rdata", 32'(m_rdata), 32'(sb[0].rdata));
                        last_hs = cyc + 1;
                        void'(sb.pop_front());
                        front_strobed = 1'b0;
                    end
                end
            end
            prev_rv = m_rsp_valid && !rsp_ready;
        end
    end

    // Write-strobe counter armed for the reset-abort scenario.
    bit arm_cnt = 1'b0;
    int ws_cnt = 0;
    always @(posedge clk) if (arm_cnt && if1.write_strobe) ws_cnt <= ws_cnt + 1;

    // Present a command, wait for acceptance, record the expectation.
    task automatic send(input bit wr, input logic [7:0] a, input logic [7:0] d,
                        input bit hold, output int t);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!m_cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("accept_timeout", 32'(n >= 50), 32'd0);
        t = cyc + 1;
        if (n < 50) sb.push_back('{wr, a, d, wr ? 8'h00 : periph_val(a), t});
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("drain_timeout", 32'(n >= 100), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_cmd_ready"}, 32'(if1.cmd_ready), 32'd0);
        check_val({tag, "_rsp_valid"}, 32'(if1.rsp_valid), 32'd0);
        check_val({tag, "_rsp_rdata"}, 32'(if1.rsp_rdata), 32'd0);
        check_val({tag, "_port_id"},   32'(if1.port_id),   32'd0);
        check_val({tag, "_out_port"},  32'(if1.out_port),  32'd0);
        check_val({tag, "_wstrobe"},   32'(if1.write_strobe), 32'd0);
        check_val({tag, "_rstrobe"},   32'(if1.read_strobe),  32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int t, t2;
        int n;
        logic [7:0] held;

        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check_val("ready_after_reset", 32'(if1.cmd_ready), 32'd1);

        // Write 0x02 <- 0xA5.
        send(1'b1, 8'h02, 8'hA5, 1'b0, t);
        check_val("setup_port_id", 32'(m_pid), 32'h02);
        check_val("setup_out_port", 32'(m_out), 32'hA5);
        wait_idle();
        check_val("retain_port_id", 32'(m_pid), 32'h02);
        check_val("retain_out_port", 32'(m_out), 32'hA5);

        // Read, latency 1.
        send(1'b0, 8'h01, 8'h00, 1'b0, t);
        wait_idle();

        // Back-to-back with cmd_valid held high.
        send(1'b1, 8'h10, 8'h11, 1'b1, t);
        send(1'b0, 8'h20, 8'h00, 1'b1, t2);
        check_val("b2b_gap_1", 32'(t2), 32'(last_hs + 1));
        send(1'b1, 8'h30, 8'hC7, 1'b0, t);
        check_val("b2b_gap_2", 32'(t), 32'(last_hs + 1));
        wait_idle();

        // Backpressure on a read response.
        rsp_ready = 1'b0;
        send(1'b0, 8'h05, 8'h00, 1'b0, t);
        n = 0;
        while (!m_rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("bp_valid_timeout", 32'(n >= 50), 32'd0);
        held = m_rdata;
        for (int i = 0; i < 5; i++) begin
            check_val("bp_valid", 32'(m_rsp_valid), 32'd1);
            check_val("bp_rdata", 32'(m_rdata), 32'(periph_val(8'h05)));
            check_val("bp_hold", 32'(m_rdata), 32'(held));
            check_val("bp_cmd_ready", 32'(m_cmd_ready), 32'd0);
            check_val("bp_strobes", 32'(m_ws | m_rs), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        wait_idle();

        // Latency 4 instance.
        sel = 1'b1;
        @(negedge clk);
        send(1'b0, 8'h40, 8'h00, 1'b0, t);
        wait_idle();
        send(1'b1, 8'h41, 8'h3E, 1'b0, t);
        wait_idle();
        sel = 1'b0;
        @(negedge clk);

        // Reset during SETUP of a write.
        arm_cnt = 1'b1;
        send(1'b1, 8'h09, 8'hC3, 1'b0, t);
        #2;
        reset = 1'b1;
        #1;
        check_zero_outputs("abort");
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_val("abort_ready_pre_edge", 32'(if1.cmd_ready), 32'd0);
        @(negedge clk);
        check_val("abort_ready_post_edge", 32'(if1.cmd_ready), 32'd1);
        repeat (6) @(negedge clk);
        check_val("abort_no_wstrobe", 32'(ws_cnt), 32'd0);
        check_val("abort_port_id", 32'(if1.port_id), 32'd0);
        check_val("abort_no_rsp", 32'(if1.rsp_valid), 32'd0);

        // Normal operation after the abort.
        send(1'b0, 8'h07, 8'h00, 1'b0, t);
        wait_idle();

`ifdef PB_PORT_MASTER_IRQ_EN
        // Single-cycle interrupt pulse.
        irq_in = 1'b1;
        @(negedge clk);
        irq_in = 1'b0;
        @(negedge clk);
        check_val("irq_not_yet", 32'(irq_pend1), 32'd0);
        @(negedge clk);
        check_val("irq_set", 32'(irq_pend1), 32'd1);
        @(negedge clk);
        check_val("irq_sticky", 32'(irq_pend1), 32'd1);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        check_val("irq_acked", 32'(irq_pend1), 32'd0);
        // Ack lands on the same edge as a new rising edge.
        irq_in = 1'b1;
        @(negedge clk);
        irq_in = 1'b0;
        @(negedge clk);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        check_val("irq_edge_beats_ack", 32'(irq_pend1), 32'd1);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pb_port_master.md
PB_PORT_MASTER -- requirements
Module: pb_port_master

Interface
REQ-001 The module SHALL take parameter READ_LATENCY, default 1, range 1..4: cycles from read_strobe to in_port capture.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The module SHALL have port cmd_valid, input, 1 bit: command request.
REQ-005 The module SHALL have port cmd_ready, output, 1 bit: command accepted when high with cmd_valid.
REQ-006 The module SHALL have port cmd_write, input, 1 bit: 1 = write, 0 = read.
REQ-007 The module SHALL have port cmd_addr, input, 8 bits: target port address.
REQ-008 The module SHALL have port cmd_wdata, input, 8 bits: write data.
REQ-009 The module SHALL have port rsp_valid, output, 1 bit: response available.
REQ-010 The module SHALL have port rsp_ready, input, 1 bit: response consumed.
REQ-011 The module SHALL have port rsp_rdata, output, 8 bits: read data; 0x00 for writes.
REQ-012 The module SHALL have port port_id, output, 8 bits: peripheral address.
REQ-013 The module SHALL have port out_port, output, 8 bits: peripheral write data.
REQ-014 The module SHALL have port write_strobe, output, 1 bit: one-cycle write pulse.
REQ-015 The module SHALL have port read_strobe, output, 1 bit: one-cycle read pulse.
REQ-016 The module SHALL have port in_port, input, 8 bits: peripheral registered read data.

Function
REQ-017 The FSM SHALL have states IDLE, SETUP, STROBE, WAIT and RESP.
- IDLE->SETUP on cmd_valid&&cmd_ready.
- SETUP->STROBE always.
- STROBE->RESP for writes, STROBE->WAIT for reads.
- WAIT->RESP after READ_LATENCY cycles.
- RESP->IDLE on rsp_ready.
REQ-018 cmd_ready SHALL be high only in IDLE; cmd_addr, cmd_wdata and cmd_write SHALL be registered at the acceptance edge.
REQ-019 port_id and out_port SHALL take the registered values in SETUP and hold them through STROBE and WAIT; after the transaction they SHALL retain their last values.
REQ-020 The strobes SHALL be asserted only in STROBE, for exactly one cycle: write_strobe for writes, read_strobe for reads; the two SHALL never be high together.
REQ-021 For reads, in_port SHALL be captured into rsp_rdata at the end of the last WAIT cycle (cycle STROBE+READ_LATENCY).
REQ-022 Latency from an acceptance edge at cycle T:
- write strobe at T+2, rsp_valid at T+3;
- read strobe at T+2, rsp_valid at T+3+READ_LATENCY.
REQ-023 rsp_valid and rsp_rdata SHALL hold stable in RESP until rsp_ready; a new command SHALL NOT be accepted in the cycle rsp_ready is taken, and the earliest next acceptance is the following cycle.
REQ-024 For back-to-back commands with cmd_valid held high, each command SHALL see the full SETUP/STROBE sequence, with no overlap.

Reset
REQ-025 Reset assertion SHALL immediately force IDLE and drive the following outputs to 0 / 0x00: cmd_ready, rsp_valid, rsp_rdata, port_id, out_port, write_strobe and read_strobe.
REQ-026 Reset mid-transaction SHALL abort the transaction with no strobe and no response issued afterwards; cmd_ready SHALL go high on the first edge after deassertion.

Configuration
REQ-027 With PB_PORT_MASTER_IRQ_EN defined, the module SHALL add the following ports:
- interrupt, input, 1 bit;
- irq_ack, input, 1 bit;
- irq_pending, output, 1 bit.
REQ-028 With the macro defined, interrupt SHALL pass through a 2-flop synchronizer, and a rising edge SHALL set sticky irq_pending.
REQ-029 With the macro defined, irq_ack SHALL clear irq_pending; a simultaneous new edge and irq_ack SHALL leave irq_pending set; irq_pending SHALL reset to 0.
REQ-030 Without the macro, these ports and their logic SHALL be absent.

Structure
REQ-031 Package pb_port_pkg SHALL hold the following:
- FSM state encoding;
- ADDR_W=8 and DATA_W=8;
- READ_LATENCY default and maximum constants.
REQ-032 Sub-module pb_irq_sync, holding the synchronizer and sticky latch, SHALL exist only under PB_PORT_MASTER_IRQ_EN; the FSM and datapath SHALL stay in pb_port_master.

Verification
REQ-033 The bench SHALL cover a write: cmd addr 0x02, wdata 0xA5, accepted at T -> port_id=0x02, out_port=0xA5, write_strobe high only at T+2, rsp_valid at T+3 with rsp_rdata=0x00.
REQ-034 The bench SHALL cover a read, READ_LATENCY=1: addr 0x01, in_port=0x3C registered by a model peripheral -> read_strobe at T+2, rsp_valid at T+4 with rsp_rdata=0x3C.
REQ-035 The bench SHALL cover READ_LATENCY=4: rsp_valid at T+7, with in_port changing to 0x5A only at T+6 -> rsp_rdata=0x5A.
REQ-036 The bench SHALL cover backpressure: rsp_ready low for 5 cycles -> rsp_valid and rsp_rdata stable, cmd_ready low, no strobes.
REQ-037 The bench SHALL cover reset asserted during SETUP of a write -> no write_strobe ever, all outputs 0, cmd_ready=1 one edge after release.
REQ-038 The bench SHALL cover the macro-enabled build: interrupt pulse -> irq_pending=1 three edges later; irq_ack -> irq_pending=0; coincident edge and irq_ack -> irq_pending stays 1.
